logic_op_pipe: RTL and testbench

LOGIC_OP_PIPE -- requirements
Module: logic_op_pipe

---
 rtl/logic_op_pipe.sv | 81 ++++++++
 tb/tb_logic_op_pipe.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
// Bitwise logic unit (AND/OR/XOR/NAND) with a holdable LATENCY-stage result pipeline
// and a saturating counter of nonzero results leaving the pipe.
module logic_op_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pi_a,
  input  logic [WIDTH-1:0] pi_b,
  input  logic [1:0]       pi_op,
  input  logic             pi_valid,
  input  logic             pi_hold,
  input  logic             pi_cnt_clr,
  output logic [WIDTH-1:0] po_c1,
  output logic             po_valid,
  output logic [WIDTH-1:0] po_c2,
  output logic [CNT_W-1:0] po_cnt,
  output logic             po_cnt_sat
);

  logic [WIDTH-1:0]              w_res;
  logic [LATENCY:1]              r_vld_pipe;
  logic [LATENCY:1][WIDTH-1:0]   r_dat_pipe;
  logic [LATENCY:1]              w_vin;
  logic [LATENCY:1][WIDTH-1:0]   w_din;
  logic [CNT_W-1:0]              r_cnt;
  logic                          w_cnt_inc;

  always_comb begin
    case (pi_op)
      2'b00:   w_res = pi_a & pi_b;
      2'b01:   w_res = pi_a | pi_b;
      2'b10:   w_res = pi_a ^ pi_b;
      default: w_res = ~(pi_a & pi_b);
    endcase
  end

  assign po_c2 = w_res;

  // Stage s is fed by stage s-1; stage 1 is fed by the freshly computed result.
  always_comb begin
    w_vin    = '0;
    w_din    = '0;
    w_vin[1] = pi_valid;
    w_din[1] = w_res;
    for (int s = 2; s <= LATENCY; s++) begin
      w_vin[s] = r_vld_pipe[s-1];
      w_din[s] = r_dat_pipe[s-1];
    end
  end

  // Bubbles advance the valid bits but never overwrite data, so the output
  // word keeps the last valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else if (!pi_hold) begin
      for (int s = 1; s <= LATENCY; s++) begin
        r_vld_pipe[s] <= w_vin[s];
        if (w_vin[s]) r_dat_pipe[s] <= w_din[s];
      end
    end
  end

  assign w_cnt_inc = !pi_hold && w_vin[LATENCY] && (|w_din[LATENCY]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (pi_cnt_clr)             r_cnt <= '0;
    else if (w_cnt_inc && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign po_c1      = r_dat_pipe[LATENCY];
  assign po_valid   = r_vld_pipe[LATENCY];
  assign po_cnt     = r_cnt;
  assign po_cnt_sat = &r_cnt;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: default config, a 2-bit counter config,
// and a 1-bit single-stage config for the full truth table.
module tb_logic_op_pipe;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  // u0: defaults
  logic [7:0]  a0 = 0, b0 = 0, c1_0, c2_0;
  logic [1:0]  op0 = 0;
  logic        v0 = 0, h0 = 0, clr0 = 0, vld_0, sat_0;
  logic [15:0] cnt_0;
  // u1: CNT_W=2
  logic [7:0]  a1 = 0, b1 = 0, c1_1, c2_1;
  logic [1:0]  op1 = 0;
  logic        v1 = 0, h1 = 0, clr1 = 0, vld_1, sat_1;
  logic [1:0]  cnt_1;
  // u2: WIDTH=1, LATENCY=1
  logic        a2 = 0, b2 = 0, c1_2, c2_2;
  logic [1:0]  op2 = 0;
  logic        v2 = 0, h2 = 0, clr2 = 0, vld_2, sat_2;
  logic [15:0] cnt_2;

  logic_op_pipe u0 (.clk(clk), .rst_n(rst_n), .pi_a(a0), .pi_b(b0), .pi_op(op0),
    .pi_valid(v0), .pi_hold(h0), .pi_cnt_clr(clr0), .po_c1(c1_0), .po_valid(vld_0),
    .po_c2(c2_0), .po_cnt(cnt_0), .po_cnt_sat(sat_0));

  logic_op_pipe #(.CNT_W(2)) u1 (.clk(clk), .rst_n(rst_n), .pi_a(a1), .pi_b(b1), .pi_op(op1),
    .pi_valid(v1), .pi_hold(h1), .pi_cnt_clr(clr1), .po_c1(c1_1), .po_valid(vld_1),
    .po_c2(c2_1), .po_cnt(cnt_1), .po_cnt_sat(sat_1));

  logic_op_pipe #(.WIDTH(1), .LATENCY(1)) u2 (.clk(clk), .rst_n(rst_n), .pi_a(a2), .pi_b(b2),
    .pi_op(op2), .pi_valid(v2), .pi_hold(h2), .pi_cnt_clr(clr2), .po_c1(c1_2),
    .po_valid(vld_2), .po_c2(c2_2), .po_cnt(cnt_2), .po_cnt_sat(sat_2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    total++; if (c1_0 !== 8'h00) $display("FAIL reset_c1 got %h exp 00", c1_0); else pass_cnt++;
    total++; if (vld_0 !== 1'b0) $display("FAIL reset_valid got %b exp 0", vld_0); else pass_cnt++;
    total++; if (cnt_0 !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", cnt_0); else pass_cnt++;
    total++; if (sat_0 !== 1'b0) $display("FAIL reset_sat got %b exp 0", sat_0); else pass_cnt++;
    #11 rst_n = 1;
    tick();
  endtask

  task automatic test_basic;
    a0 = 8'hF0; b0 = 8'h3C; op0 = 2'b00; v0 = 1;
    #1;
    total++; if (c2_0 !== 8'h30) $display("FAIL basic_c2 got %h exp 30", c2_0); else pass_cnt++;
    tick(); v0 = 0;
    total++; if (vld_0 !== 1'b0) $display("FAIL basic_early_valid got %b exp 0", vld_0); else pass_cnt++;
    tick();
    total++; if (c1_0 !== 8'h30) $display("FAIL basic_c1 got %h exp 30", c1_0); else pass_cnt++;
    total++; if (vld_0 !== 1'b1) $display("FAIL basic_valid got %b exp 1", vld_0); else pass_cnt++;
    total++; if (cnt_0 !== 16'd1) $display("FAIL basic_cnt got %0d exp 1", cnt_0); else pass_cnt++;
    tick();
    total++; if (vld_0 !== 1'b0) $display("FAIL basic_pulse got %b exp 0", vld_0); else pass_cnt++;
    total++; if (c1_0 !== 8'h30) $display("FAIL basic_keep got %h exp 30", c1_0); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    a0 = 8'hF0; b0 = 8'h0F; op0 = 2'b01; v0 = 1;
    tick();
    a0 = 8'hAA; b0 = 8'hAA; op0 = 2'b10;
    tick();
    total++; if (c1_0 !== 8'hFF || vld_0 !== 1'b1) $display("FAIL b2b_or got %h/%b exp FF/1", c1_0, vld_0); else pass_cnt++;
    total++; if (cnt_0 !== 16'd2) $display("FAIL b2b_cnt1 got %0d exp 2", cnt_0); else pass_cnt++;
    a0 = 8'hFF; b0 = 8'hFF; op0 = 2'b11;
    tick(); v0 = 0;
    total++; if (c1_0 !== 8'h00 || vld_0 !== 1'b1) $display("FAIL b2b_xor got %h/%b exp 00/1", c1_0, vld_0); else pass_cnt++;
    tick();
    total++; if (c1_0 !== 8'h00 || vld_0 !== 1'b1) $display("FAIL b2b_nand got %h/%b exp 00/1", c1_0, vld_0); else pass_cnt++;
    total++; if (cnt_0 !== 16'd2) $display("FAIL b2b_cnt2 got %0d exp 2", cnt_0); else pass_cnt++;
    tick();
    total++; if (vld_0 !== 1'b0) $display("FAIL b2b_end got %b exp 0", vld_0); else pass_cnt++;
  endtask

  task automatic test_hold;
    a0 = 8'h0F; b0 = 8'h0F; op0 = 2'b00; v0 = 1;
    tick();                                  // edge 0
    v0 = 0; h0 = 1;
    tick();                                  // edge 1
    total++; if (vld_0 !== 1'b0) $display("FAIL hold_e1 got %b exp 0", vld_0); else pass_cnt++;
    a0 = 8'hFF; b0 = 8'hFF; op0 = 2'b01; v0 = 1;
    tick();                                  // edge 2, dropped
    v0 = 0;
    tick();                                  // edge 3
    total++; if (vld_0 !== 1'b0) $display("FAIL hold_e3 got %b exp 0", vld_0); else pass_cnt++;
    h0 = 0;
    tick();                                  // edge 4
    total++; if (c1_0 !== 8'h0F || vld_0 !== 1'b1) $display("FAIL hold_out got %h/%b exp 0F/1", c1_0, vld_0); else pass_cnt++;
    total++; if (cnt_0 !== 16'd3) $display("FAIL hold_cnt got %0d exp 3", cnt_0); else pass_cnt++;
    tick();
    total++; if (c1_0 !== 8'h0F || vld_0 !== 1'b0) $display("FAIL hold_drop got %h/%b exp 0F/0", c1_0, vld_0); else pass_cnt++;
    a0 = 8'h55; b0 = 8'h0F; op0 = 2'b10; v0 = 1;
    tick(); v0 = 0;
    tick();
    total++; if (c1_0 !== 8'h5A || vld_0 !== 1'b1) $display("FAIL hold2_out got %h/%b exp 5A/1", c1_0, vld_0); else pass_cnt++;
    h0 = 1;
    tick();
    total++; if (vld_0 !== 1'b1 || cnt_0 !== 16'd4) $display("FAIL hold2_keep got %b/%0d exp 1/4", vld_0, cnt_0); else pass_cnt++;
    h0 = 0;
    tick();
    total++; if (vld_0 !== 1'b0 || cnt_0 !== 16'd4) $display("FAIL hold2_rel got %b/%0d exp 0/4", vld_0, cnt_0); else pass_cnt++;
  endtask

  task automatic test_saturate;
    logic [1:0] exp_cnt;
    a1 = 8'h01; b1 = 8'h00; op1 = 2'b01; v1 = 1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 5) v1 = 0;
      exp_cnt = (t - 1 > 3) ? 2'd3 : 2'(t - 1);
      total++; if (cnt_1 !== exp_cnt) $display("FAIL sat_cnt_t%0d got %0d exp %0d", t, cnt_1, exp_cnt); else pass_cnt++;
      total++; if (sat_1 !== (t >= 4)) $display("FAIL sat_flag_t%0d got %b exp %b", t, sat_1, (t >= 4)); else pass_cnt++;
    end
    v1 = 1;
    tick(); v1 = 0; clr1 = 1;
    tick(); clr1 = 0;
    total++; if (vld_1 !== 1'b1 || cnt_1 !== 2'd0 || sat_1 !== 1'b0)
      $display("FAIL sat_clr got %b/%0d/%b exp 1/0/0", vld_1, cnt_1, sat_1); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    a0 = 8'h12; b0 = 8'h34; op0 = 2'b01; v0 = 1;
    tick();
    a0 = 8'hC3; b0 = 8'h3C; op0 = 2'b10;
    tick(); v0 = 0;
    #2 rst_n = 0;
    #1;
    total++; if (c1_0 !== 8'h00 || vld_0 !== 1'b0) $display("FAIL arst_out got %h/%b exp 00/0", c1_0, vld_0); else pass_cnt++;
    total++; if (cnt_0 !== 16'd0 || sat_0 !== 1'b0) $display("FAIL arst_cnt got %0d/%b exp 0/0", cnt_0, sat_0); else pass_cnt++;
    #1 rst_n = 1;
    for (int t = 0; t < 3; t++) begin
      tick();
      total++; if (vld_0 !== 1'b0) $display("FAIL arst_ghost_t%0d got %b exp 0", t, vld_0); else pass_cnt++;
    end
    a0 = 8'h81; b0 = 8'h18; op0 = 2'b01; v0 = 1;
    tick(); v0 = 0;
    tick();
    total++; if (c1_0 !== 8'h99 || vld_0 !== 1'b1) $display("FAIL arst_after got %h/%b exp 99/1", c1_0, vld_0); else pass_cnt++;
  endtask

  task automatic test_truth_table;
    logic [15:0] tt;
    logic        exp_bit;
    tt = 16'b0111_0110_1110_1000;            // {NAND, XOR, OR, AND}, bit index {a,b}
    for (int op = 0; op < 4; op++)
      for (int ab = 0; ab < 4; ab++) begin
        op2 = 2'(op); a2 = ab[1]; b2 = ab[0]; v2 = 1;
        exp_bit = tt[op*4 + ab];
        #1;
        total++; if (c2_2 !== exp_bit) $display("FAIL tt_c2_op%0d_ab%0d got %b exp %b", op, ab, c2_2, exp_bit); else pass_cnt++;
        tick();
        total++; if (c1_2 !== exp_bit || vld_2 !== 1'b1)
          $display("FAIL tt_c1_op%0d_ab%0d got %b/%b exp %b/1", op, ab, c1_2, vld_2, exp_bit); else pass_cnt++;
      end
    v2 = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_saturate();
    test_truth_table();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
